// File: rtl/uart_rx_pkg.sv
//==============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and constants for the Avalon-MM UART receiver:
//               deframer state encoding, register addresses and the bit
//               positions of the STATUS and CONTROL registers.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Register map (address 3 aliases DATA)
    localparam logic [1:0] c_addr_data   = 2'd0;
    localparam logic [1:0] c_addr_status = 2'd1;
    localparam logic [1:0] c_addr_ctrl   = 2'd2;
    localparam logic [1:0] c_addr_alias  = 2'd3;

    // STATUS bit positions
    localparam int c_st_full  = 0;
    localparam int c_st_empty = 1;
    localparam int c_st_ovr   = 2;
    localparam int c_st_fe    = 3;
    localparam int c_st_pe    = 4;
    localparam int c_st_busy  = 5;
    localparam int c_st_cnt_lo = 8;

    // CONTROL bit positions
    localparam int c_ctl_en  = 0;
    localparam int c_ctl_irq = 1;
    localparam int c_ctl_w1c = 2;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync_fifo.sv
//==============================================================================
// Module      : uart_rx_sync_fifo
// Description : Show-ahead synchronous FIFO holding received characters.
//               dout always presents the oldest entry; a push and a pop in
//               the same cycle both take effect even when full.
// Ports       : clk, reset_n (async, active-low), push, pop, din[DW-1:0],
//               dout[DW-1:0], full, empty, count[W:0]
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx_sync_fifo #(
    parameter int DW = 8,
    parameter int W  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [W:0]    count
);

    logic [DW-1:0] r_mem [2**W];
    logic [W-1:0]  r_wr_ptr;
    logic [W-1:0]  r_rd_ptr;
    logic [W:0]    r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = r_count[W];
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    // When full, the slot being written is the one being read out this cycle
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo_avmm.sv
//==============================================================================
// Module      : uart_rx_fifo_avmm
// Description : Avalon-MM UART receiver. Synchronizes rdi, deframes
//               start/8 data/optional parity/stop bits and queues good
//               characters in a 2^W FIFO read through the DATA register.
// Ports       : clk, reset_n (async, active-low), address[1:0], chipselect,
//               read, write, writedata[31:0], readdata[31:0] (1-cycle
//               registered), rdi (serial in, idle high), irq
// Config      : UART_RX_IRQ_EN - when defined, irq is a registered level
//               interrupt; otherwise irq is tied low.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx_fifo_avmm #(
    parameter int P     = 0,
    parameter int W     = 4,
    parameter int s     = 1,
    parameter int TIMER = 434
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        rdi,
    output logic        irq
);

    import uart_rx_pkg::*;

    localparam int DW = 8 + P;
    localparam int CW = $clog2(TIMER + 1);

    logic          r_rdi_meta, r_rdi_sync, r_rdi_prev;
    rx_state_t     r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_tick, w_fall, w_done;
    logic [2:0]    r_bit_idx;
    logic          r_stop_idx;
    logic [7:0]    r_shift;
    logic          r_par, r_fe_pend;
    logic          r_done, r_done_fe, r_done_pe;
    logic          r_ctrl_en, r_ctrl_irq;
    logic          r_ovr, r_fe, r_pe;
    logic [31:0]   r_readdata;
    logic [DW-1:0] w_char, w_dout;
    logic          w_push, w_pop, w_full, w_empty;
    logic [W:0]    w_count;
    logic          w_rd, w_wr, w_is_data, w_good, w_ovr_set, w_w1c;
    logic [31:0]   w_status, w_data_rd, w_rd_mux;
    logic          w_unused;

    // ---------------- input synchronizer ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdi_meta <= 1'b1;
            r_rdi_sync <= 1'b1;
            r_rdi_prev <= 1'b1;
        end else begin
            r_rdi_meta <= rdi;
            r_rdi_sync <= r_rdi_meta;
            r_rdi_prev <= r_rdi_sync;
        end
    end

    assign w_fall = r_rdi_prev & ~r_rdi_sync;
    // A sample falls exactly "load value" cycles after the counter is loaded
    assign w_tick = (r_cnt == CW'(1));

    // ---------------- deframer FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CW'(1) : '0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_ctrl_en && w_fall) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = CW'(TIMER / 2);
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_cnt_nxt   = CW'(TIMER);
                    w_state_nxt = r_rdi_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_cnt_nxt = CW'(TIMER);
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = (P != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_cnt_nxt   = CW'(TIMER);
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_cnt_nxt = CW'(TIMER);
                    if (r_stop_idx == 1'(s - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_done      = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Disabling the receiver abandons any frame in progress silently
        if (!r_ctrl_en) begin
            w_state_nxt = ST_IDLE;
            w_done      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_fe_pend  <= 1'b0;
            r_done     <= 1'b0;
            r_done_fe  <= 1'b0;
            r_done_pe  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_done <= w_done;
            if (r_state == ST_IDLE) begin
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
                r_fe_pend  <= 1'b0;
            end
            if (w_tick) begin
                case (r_state)
                    ST_DATA: begin
                        r_shift   <= {r_rdi_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                    ST_PARITY: r_par <= r_rdi_sync;
                    ST_STOP: begin
                        r_fe_pend  <= r_fe_pend | ~r_rdi_sync;
                        r_stop_idx <= 1'b1;
                    end
                    default: ;
                endcase
            end
            // Error status of the finished frame, consumed by the push logic
            if (w_done) begin
                r_done_fe <= r_fe_pend | ~r_rdi_sync;
                r_done_pe <= (P != 0) && ((^r_shift) ^ r_par);
            end
        end
    end

    generate
        if (P != 0) begin : g_par
            assign w_char = DW'({r_par, r_shift});
        end else begin : g_nopar
            assign w_char = DW'(r_shift);
        end
    endgenerate

    // ---------------- FIFO ----------------
    assign w_rd      = chipselect & read;
    assign w_wr      = chipselect & write;
    assign w_is_data = (address == c_addr_data) || (address == c_addr_alias);
    assign w_pop     = w_rd & w_is_data & ~w_empty;
    assign w_good    = r_done & ~r_done_fe & ~r_done_pe;
    assign w_push    = w_good & (~w_full | w_pop);
    assign w_ovr_set = w_good & w_full & ~w_pop;
    assign w_w1c     = w_wr & (address == c_addr_ctrl) & writedata[c_ctl_w1c];

    uart_rx_sync_fifo #(
        .DW (DW),
        .W  (W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     (w_char),
        .dout    (w_dout),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl_en  <= 1'b0;
            r_ctrl_irq <= 1'b0;
            r_ovr      <= 1'b0;
            r_fe       <= 1'b0;
            r_pe       <= 1'b0;
            r_readdata <= '0;
        end else begin
            if (w_wr && (address == c_addr_ctrl)) begin
                r_ctrl_en  <= writedata[c_ctl_en];
                r_ctrl_irq <= writedata[c_ctl_irq];
            end
            // A new event in the same cycle as the clear keeps the flag set
            r_ovr      <= w_ovr_set | (r_ovr & ~w_w1c);
            r_fe       <= (r_done & r_done_fe) | (r_fe & ~w_w1c);
            r_pe       <= (r_done & r_done_pe) | (r_pe & ~w_w1c);
            r_readdata <= w_rd ? w_rd_mux : '0;
        end
    end

    always_comb begin
        w_status                          = '0;
        w_status[c_st_full]               = w_full;
        w_status[c_st_empty]              = w_empty;
        w_status[c_st_ovr]                = r_ovr;
        w_status[c_st_fe]                 = r_fe;
        w_status[c_st_pe]                 = r_pe;
        w_status[c_st_busy]               = (r_state != ST_IDLE);
        w_status[c_st_cnt_lo +: 8]        = 8'(w_count);

        w_data_rd = '0;
        if (!w_empty) begin
            w_data_rd[31]      = 1'b1;
            w_data_rd[DW-1:0]  = w_dout;
        end

        w_rd_mux = w_data_rd;
        if (address == c_addr_status) begin
            w_rd_mux = w_status;
        end else if (address == c_addr_ctrl) begin
            w_rd_mux = {30'd0, r_ctrl_irq, r_ctrl_en};
        end
    end

    assign readdata = r_readdata;

`ifdef UART_RX_IRQ_EN
    logic r_irq;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_irq <= 1'b0;
        else          r_irq <= r_ctrl_irq & (~w_empty | r_ovr | r_fe | r_pe);
    end
    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    assign w_unused = ^{writedata[31:3], r_par};

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo_avmm.sv
//==============================================================================
// Module      : tb_uart_rx_fifo_avmm
// Description : Directed self-checking bench. dut0: P=0 W=2 s=1 TIMER=16;
//               dut1: P=1 W=2 s=2 TIMER=16. Expected DATA reads are queued
//               per DUT when characters are sent and popped on each read.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_rx_fifo_avmm;

    localparam int c_timer = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        read, write;
    logic [31:0] writedata;
    logic        cs0, cs1, rdi0, rdi1;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] v;

    always #5 clk = ~clk;

    uart_rx_fifo_avmm #(.P(0), .W(2), .s(1), .TIMER(c_timer)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0),
        .read(read), .write(write), .writedata(writedata), .readdata(rd0),
        .rdi(rdi0), .irq(irq0)
    );

    uart_rx_fifo_avmm #(.P(1), .W(2), .s(2), .TIMER(c_timer)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1),
        .read(read), .write(write), .writedata(writedata), .readdata(rd1),
        .rdi(rdi1), .irq(irq1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_cs(input int d, input logic val);
        if (d == 0) cs0 = val;
        else        cs1 = val;
    endtask

    task automatic set_rdi(input int d, input logic val);
        if (d == 0) rdi0 = val;
        else        rdi1 = val;
    endtask

    task automatic bus_read(input int d, input logic [1:0] a, output logic [31:0] val);
        @(negedge clk);
        address = a;
        read    = 1'b1;
        set_cs(d, 1'b1);
        @(negedge clk);
        val  = (d == 0) ? rd0 : rd1;
        read = 1'b0;
        set_cs(d, 1'b0);
    endtask

    task automatic bus_write(input int d, input logic [1:0] a, input logic [31:0] wd);
        @(negedge clk);
        address   = a;
        writedata = wd;
        write     = 1'b1;
        set_cs(d, 1'b1);
        @(negedge clk);
        write = 1'b0;
        set_cs(d, 1'b0);
    endtask

    task automatic send(input int d, input logic [8:0] ch, input int nb,
                        input logic stop_val, input int ns);
        set_rdi(d, 1'b0);
        repeat (c_timer) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            set_rdi(d, ch[i]);
            repeat (c_timer) @(negedge clk);
        end
        for (int i = 0; i < ns; i++) begin
            set_rdi(d, stop_val);
            repeat (c_timer) @(negedge clk);
        end
        set_rdi(d, 1'b1);
    endtask

    // Read DATA and compare against the oldest queued character (0 when none)
    task automatic read_data_sb(input int d, input string tag);
        logic [31:0] got, exp;
        bus_read(d, 2'd0, got);
        exp = 32'd0;
        if (d == 0) begin
            if (q0.size() > 0) exp = q0.pop_front();
        end else begin
            if (q1.size() > 0) exp = q1.pop_front();
        end
        check(tag, got, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
        cs0 = 1'b0; cs1 = 1'b0; rdi0 = 1'b1; rdi1 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_readdata0", rd0, 32'd0);
        check("rst_irq0", {31'd0, irq0}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        bus_read(0, 2'd1, v); check("rst_status0", v, 32'h2);
        bus_read(0, 2'd2, v); check("rst_ctrl0", v, 32'h0);
        bus_read(1, 2'd1, v); check("rst_status1", v, 32'h2);
        read_data_sb(0, "rst_data0_empty");

        bus_write(0, 2'd2, 32'h1);
        bus_write(1, 2'd2, 32'h1);

        // single character
        send(0, 9'h0A5, 8, 1'b1, 1);
        q0.push_back(32'h8000_00A5);
        repeat (4) @(negedge clk);
        bus_read(0, 2'd1, v); check("one_status", v, 32'h0000_0100);
        read_data_sb(0, "one_data");
        bus_read(0, 2'd1, v); check("one_status_after", v, 32'h2);
        bus_write(0, 2'd0, 32'hFF);
        bus_read(0, 2'd1, v); check("data_write_ignored", v, 32'h2);

        // parity (dut1, even parity, two stop bits)
        send(1, 9'h107, 9, 1'b1, 2);
        q1.push_back(32'h8000_0107);
        repeat (4) @(negedge clk);
        read_data_sb(1, "par_good_data");
        send(1, 9'h007, 9, 1'b1, 2);
        repeat (4) @(negedge clk);
        bus_read(1, 2'd1, v); check("par_bad_status", v, 32'h12);
        bus_write(1, 2'd2, 32'h5);
        bus_read(1, 2'd1, v); check("par_clr_status", v, 32'h2);
        bus_read(1, 2'd2, v); check("par_ctrl_rb", v, 32'h1);

        // frame error
        send(0, 9'h03C, 8, 1'b0, 1);
        repeat (4) @(negedge clk);
        bus_read(0, 2'd1, v); check("fe_status", v, 32'hA);
        bus_write(0, 2'd2, 32'h5);
        bus_read(0, 2'd1, v); check("fe_clr_status", v, 32'h2);

        // false start glitch
        rdi0 = 1'b0;
        repeat (4) @(negedge clk);
        rdi0 = 1'b1;
        bus_read(0, 2'd1, v); check("glitch_busy", v, 32'h22);
        repeat (20) @(negedge clk);
        bus_read(0, 2'd1, v); check("glitch_idle", v, 32'h2);

        // overrun: 5 back-to-back characters into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            send(0, 9'(i), 8, 1'b1, 1);
            if (i <= 4) q0.push_back(32'h8000_0000 | 32'(i));
        end
        repeat (4) @(negedge clk);
        bus_read(0, 2'd1, v); check("ovr_status", v, 32'h0000_0405);
        for (int i = 1; i <= 5; i++) read_data_sb(0, $sformatf("ovr_data%0d", i));
        bus_read(0, 2'd1, v); check("ovr_status_after", v, 32'h6);
        bus_write(0, 2'd2, 32'h5);

        // abort mid-DATA by clearing the enable
        rdi0 = 1'b0;
        repeat (c_timer) @(negedge clk);
        rdi0 = 1'b1; repeat (c_timer) @(negedge clk);
        rdi0 = 1'b0; repeat (c_timer) @(negedge clk);
        rdi0 = 1'b1; repeat (c_timer / 2) @(negedge clk);
        bus_read(0, 2'd1, v); check("abort_busy_before", v, 32'h22);
        bus_write(0, 2'd2, 32'h0);
        bus_read(0, 2'd1, v); check("abort_idle", v, 32'h2);
        bus_write(0, 2'd2, 32'h1);
        repeat (8 * c_timer) @(negedge clk);
        bus_read(0, 2'd1, v); check("abort_no_push", v, 32'h2);

        // interrupt
        bus_write(0, 2'd2, 32'h3);
        send(0, 9'h055, 8, 1'b1, 1);
        q0.push_back(32'h8000_0055);
        repeat (4) @(negedge clk);
`ifdef UART_RX_IRQ_EN
        check("irq_set", {31'd0, irq0}, 32'd1);
`else
        check("irq_tied_low", {31'd0, irq0}, 32'd0);
`endif
        read_data_sb(0, "irq_data");
        @(negedge clk);
        check("irq_clear", {31'd0, irq0}, 32'd0);

        // reset in the middle of a frame with a character held in the FIFO
        send(1, 9'h0FF, 9, 1'b1, 2);
        repeat (4) @(negedge clk);
        bus_read(1, 2'd1, v); check("prereset_status1", v, 32'h0000_0100);
        rdi1 = 1'b0;
        repeat (40) @(negedge clk);
        address = 2'd1; read = 1'b1; cs1 = 1'b1;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_readdata1", rd1, 32'd0);
        check("mid_rst_readdata0", rd0, 32'd0);
        read = 1'b0; cs1 = 1'b0; rdi1 = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        q1.delete();
        repeat (2) @(negedge clk);
        bus_read(1, 2'd1, v); check("post_rst_status1", v, 32'h2);
        bus_read(1, 2'd2, v); check("post_rst_ctrl1", v, 32'h0);
        read_data_sb(1, "post_rst_data1");
        bus_read(0, 2'd2, v); check("post_rst_ctrl0", v, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
